// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory: a user/loader
// port and a CPU port, round-robin with a bounded CPU lock and 1-cycle read return.
module mem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              u_req,
  input  logic              u_we,
  input  logic [ADDR_W-1:0] u_addr,
  input  logic [DATA_W-1:0] u_wdata,
  output logic              u_gnt,
  output logic              u_rvalid,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              c_lock,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {OWN_USER = 1'b0, OWN_CPU = 1'b1} owner_e;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_USER = 2'd1, TAG_CPU = 2'd2} tag_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

  owner_e     last_owner_q, last_owner_d;
  logic       lock_active_q, lock_active_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  tag_e       rd_tag_q, rd_tag_d;

  logic c_eff, u_win, c_win;
  acc_t u_acc, c_acc, sel_acc;

  assign u_acc = '{we: u_we, addr: u_addr, wdata: u_wdata};
  assign c_acc = '{we: c_we, addr: c_addr, wdata: c_wdata};

  // Grant decision; held off entirely while reset is low so nothing reaches memory.
  always_comb begin
    c_eff = c_req & cpu_en;
    u_win = 1'b0;
    c_win = 1'b0;
    if (reset) begin
      if (u_req && c_eff) begin
        if (lock_active_q) begin
          if (lock_cnt_q < LOCK_LIM) c_win = 1'b1;
          else                       u_win = 1'b1;
        end else if (last_owner_q == OWN_CPU) begin
          u_win = 1'b1;
        end else begin
          c_win = 1'b1;
        end
      end else begin
        u_win = u_req;
        c_win = c_eff;
      end
    end
  end

  always_comb begin
    sel_acc = '0;
    if (u_win)      sel_acc = u_acc;
    else if (c_win) sel_acc = c_acc;
  end

  assign u_gnt     = u_win;
  assign c_gnt     = c_win;
  assign mem_en    = u_win | c_win;
  assign mem_we    = sel_acc.we;
  assign mem_addr  = sel_acc.addr;
  assign mem_wdata = sel_acc.wdata;

  always_comb begin
    last_owner_d = last_owner_q;
    rd_tag_d     = TAG_NONE;
    if (u_win) begin
      last_owner_d = OWN_USER;
      rd_tag_d     = u_we ? TAG_NONE : TAG_USER;
    end else if (c_win) begin
      last_owner_d = OWN_CPU;
      rd_tag_d     = c_we ? TAG_NONE : TAG_CPU;
    end
    // Lock survives only across consecutive locked CPU grants; a user grant drops it.
    lock_active_d = c_win & c_lock;
    lock_cnt_d    = lock_cnt_q;
    if (!lock_active_d)
      lock_cnt_d = '0;
    else if (c_win && lock_active_q && u_req && lock_cnt_q < LOCK_LIM)
      lock_cnt_d = lock_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner_q  <= OWN_CPU;
      lock_active_q <= 1'b0;
      lock_cnt_q    <= '0;
      rd_tag_q      <= TAG_NONE;
    end else begin
      last_owner_q  <= last_owner_d;
      lock_active_q <= lock_active_d;
      lock_cnt_q    <= lock_cnt_d;
      rd_tag_q      <= rd_tag_d;
    end
  end

  assign rdata    = mem_rdata;
  assign u_rvalid = (rd_tag_q == TAG_USER);
  assign c_rvalid = (rd_tag_q == TAG_CPU);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter with a behavioural
// 256x8 synchronous memory attached to the mem_* side.
module tb_mem_port_arbiter;

  logic       clk, reset, cpu_en;
  logic       u_req, u_we, u_gnt, u_rvalid;
  logic [7:0] u_addr, u_wdata;
  logic       c_req, c_we, c_lock, c_gnt, c_rvalid;
  logic [7:0] c_addr, c_wdata, rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en),
    .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_gnt(u_gnt), .u_rvalid(u_rvalid),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_lock(c_lock),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic       ur, uw;
    logic [7:0] ua, ud;
    logic       cr, cw;
    logic [7:0] ca, cd;
    logic       cl, ce;
    logic       eug, ecg, eurv, ecrv;
    logic [7:0] erd;
    logic       emen;
    logic [7:0] ema;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic ur, uw, input logic [7:0] ua, ud,
    input logic cr, cw, input logic [7:0] ca, cd, input logic cl, ce,
    input logic eug, ecg, eurv, ecrv, input logic [7:0] erd,
    input logic emen, input logic [7:0] ema);
    vec_t t;
    t.ur = ur; t.uw = uw; t.ua = ua; t.ud = ud;
    t.cr = cr; t.cw = cw; t.ca = ca; t.cd = cd; t.cl = cl; t.ce = ce;
    t.eug = eug; t.ecg = ecg; t.eurv = eurv; t.ecrv = ecrv; t.erd = erd;
    t.emen = emen; t.ema = ema;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input vec_t t);
    u_req = t.ur; u_we = t.uw; u_addr = t.ua; u_wdata = t.ud;
    c_req = t.cr; c_we = t.cw; c_addr = t.ca; c_wdata = t.cd;
    c_lock = t.cl; cpu_en = t.ce;
  endtask

  initial begin
    // Reset held low with both requesting: nothing may be granted.
    reset = 1'b0; cpu_en = 1'b1;
    u_req = 1'b1; u_we = 1'b0; u_addr = 8'h00; u_wdata = 8'h00;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00; c_lock = 1'b0;
    #2;
    chk("rst u_gnt", u_gnt, 1'b0);
    chk("rst c_gnt", c_gnt, 1'b0);
    chk("rst mem_en", mem_en, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst u_rvalid", u_rvalid, 1'b0);
    chk("rst c_rvalid", c_rvalid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    //               ur uw ua     ud     cr cw ca     cd     cl ce  ug cg urv crv rd     men ma
    vecs.push_back(v(1, 1, 8'h00, 8'h18, 1, 0, 8'h00, 8'h00, 0, 1,  1, 0, 0, 0, 8'h00, 1, 8'h00));
    vecs.push_back(v(1, 1, 8'h01, 8'hAA, 1, 0, 8'h00, 8'h00, 0, 0,  1, 0, 0, 0, 8'h00, 1, 8'h01));
    vecs.push_back(v(1, 1, 8'h02, 8'h19, 1, 0, 8'h00, 8'h00, 0, 0,  1, 0, 0, 0, 8'h00, 1, 8'h02));
    vecs.push_back(v(1, 1, 8'h03, 8'h55, 1, 0, 8'h00, 8'h00, 0, 0,  1, 0, 0, 0, 8'h00, 1, 8'h03));
    vecs.push_back(v(1, 0, 8'h02, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1,  0, 1, 0, 0, 8'h00, 1, 8'h00));
    vecs.push_back(v(1, 0, 8'h02, 8'h00, 1, 0, 8'h01, 8'h00, 0, 1,  1, 0, 0, 1, 8'h18, 1, 8'h02));
    vecs.push_back(v(1, 0, 8'h03, 8'h00, 1, 0, 8'h01, 8'h00, 0, 1,  0, 1, 1, 0, 8'h19, 1, 8'h01));
    vecs.push_back(v(1, 0, 8'h03, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1,  1, 0, 0, 1, 8'hAA, 1, 8'h03));
    vecs.push_back(v(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1,  0, 1, 1, 0, 8'h55, 1, 8'h02));
    vecs.push_back(v(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1,  0, 0, 0, 1, 8'h19, 0, 8'h00));
    vecs.push_back(v(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1,  1, 0, 0, 0, 8'h00, 1, 8'h03));
    // Locked two-byte fetch, user held off until the lock drops.
    vecs.push_back(v(1, 0, 8'h01, 8'h00, 1, 0, 8'h00, 8'h00, 1, 1,  0, 1, 1, 0, 8'h55, 1, 8'h00));
    vecs.push_back(v(1, 0, 8'h01, 8'h00, 1, 0, 8'h01, 8'h00, 0, 1,  0, 1, 0, 1, 8'h18, 1, 8'h01));
    vecs.push_back(v(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1,  1, 0, 0, 1, 8'hAA, 1, 8'h01));
    // Lock held continuously: locking grant + 4 counted grants, then user.
    vecs.push_back(v(1, 0, 8'h03, 8'h00, 1, 0, 8'h00, 8'h00, 1, 1,  0, 1, 1, 0, 8'hAA, 1, 8'h00));
    vecs.push_back(v(1, 0, 8'h03, 8'h00, 1, 0, 8'h01, 8'h00, 1, 1,  0, 1, 0, 1, 8'h18, 1, 8'h01));
    vecs.push_back(v(1, 0, 8'h03, 8'h00, 1, 0, 8'h02, 8'h00, 1, 1,  0, 1, 0, 1, 8'hAA, 1, 8'h02));
    vecs.push_back(v(1, 0, 8'h03, 8'h00, 1, 0, 8'h03, 8'h00, 1, 1,  0, 1, 0, 1, 8'h19, 1, 8'h03));
    vecs.push_back(v(1, 0, 8'h03, 8'h00, 1, 0, 8'h00, 8'h00, 1, 1,  0, 1, 0, 1, 8'h55, 1, 8'h00));
    vecs.push_back(v(1, 0, 8'h03, 8'h00, 1, 0, 8'h01, 8'h00, 1, 1,  1, 0, 0, 1, 8'h18, 1, 8'h03));
    // Re-lock: counter must have restarted, so CPU wins the next tie.
    vecs.push_back(v(0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 1, 1,  0, 1, 1, 0, 8'h55, 1, 8'h01));
    vecs.push_back(v(1, 0, 8'h02, 8'h00, 1, 0, 8'h02, 8'h00, 1, 1,  0, 1, 0, 1, 8'hAA, 1, 8'h02));
    vecs.push_back(v(1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1,  1, 0, 0, 1, 8'h19, 1, 8'h02));
    // User write vs CPU read of the same address; CPU retries and sees new data.
    vecs.push_back(v(0, 0, 8'h00, 8'h00, 1, 0, 8'h04, 8'h00, 0, 1,  0, 1, 1, 0, 8'h19, 1, 8'h04));
    vecs.push_back(v(1, 1, 8'h05, 8'h77, 1, 0, 8'h05, 8'h00, 0, 1,  1, 0, 0, 1, 8'h00, 1, 8'h05));
    vecs.push_back(v(0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00, 0, 1,  0, 1, 0, 0, 8'h00, 1, 8'h05));
    vecs.push_back(v(0, 0, 8'h00, 8'h00, 1, 1, 8'h06, 8'h3C, 0, 1,  0, 1, 0, 1, 8'h77, 1, 8'h06));
    vecs.push_back(v(1, 0, 8'h06, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1,  1, 0, 0, 0, 8'h00, 1, 8'h06));
    vecs.push_back(v(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1,  0, 0, 1, 0, 8'h3C, 0, 8'h00));
    // cpu_en dropped mid-lock: lock clears, next tie goes to user.
    vecs.push_back(v(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1, 1,  0, 1, 0, 0, 8'h00, 1, 8'h00));
    vecs.push_back(v(0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 1, 0,  0, 0, 0, 1, 8'h18, 0, 8'h00));
    vecs.push_back(v(1, 0, 8'h01, 8'h00, 1, 0, 8'h01, 8'h00, 1, 1,  1, 0, 0, 0, 8'h00, 1, 8'h01));
    vecs.push_back(v(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1,  0, 0, 1, 0, 8'hAA, 0, 8'h00));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #2;
      chk($sformatf("row%0d u_gnt", i), u_gnt, vecs[i].eug);
      chk($sformatf("row%0d c_gnt", i), c_gnt, vecs[i].ecg);
      chk($sformatf("row%0d u_rvalid", i), u_rvalid, vecs[i].eurv);
      chk($sformatf("row%0d c_rvalid", i), c_rvalid, vecs[i].ecrv);
      chk($sformatf("row%0d mem_en", i), mem_en, vecs[i].emen);
      if (vecs[i].eurv || vecs[i].ecrv)
        chk($sformatf("row%0d rdata", i), rdata, vecs[i].erd);
      if (vecs[i].emen)
        chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].ema);
      @(posedge clk); #1;
    end

    // Reset asserted the cycle after a CPU read grant drops the pending rvalid.
    u_req = 1'b0; u_we = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 8'h00;
    c_lock = 1'b0; cpu_en = 1'b1;
    #2;
    chk("mid-rst c_gnt", c_gnt, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid-rst c_rvalid", c_rvalid, 1'b0);
    chk("mid-rst c_gnt held", c_gnt, 1'b0);
    chk("mid-rst mem_en", mem_en, 1'b0);
    @(posedge clk); #1;
    chk("mid-rst c_rvalid later", c_rvalid, 1'b0);
    reset = 1'b1;
    u_req = 1'b1; u_addr = 8'h02; c_req = 1'b1; c_addr = 8'h00;
    #2;
    chk("post-rst u_gnt", u_gnt, 1'b1);
    chk("post-rst c_gnt", c_gnt, 1'b0);
    chk("post-rst c_rvalid", c_rvalid, 1'b0);
    @(posedge clk); #1;
    chk("post-rst u_rvalid", u_rvalid, 1'b1);
    chk("post-rst rdata", rdata, 8'h19);
    chk("post-rst c_rvalid2", c_rvalid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
